// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types for the display page sequencer
// Purpose: page and FSM enums, page count, snapshot record and page-advance helper.
// Ports: none (package).
package display_pkg;

    typedef enum logic [1:0] {
        PG_PRICE = 2'd0,
        PG_STATS = 2'd1,
        PG_TRADE = 2'd2
    } page_t;

    typedef enum logic [1:0] {
        LIVE       = 2'd0,
        FROZEN_ON  = 2'd1,
        FROZEN_OFF = 2'd2
    } fsm_t;

    localparam int PAGE_COUNT = 3;

    // Everything the display can show, captured as one unit on halt.
    typedef struct packed {
        logic [7:0] buy_price;
        logic [7:0] sell_price;
        logic [7:0] spread_now;
        logic [7:0] trade_count;
        logic [7:0] last_price;
        logic [1:0] state;
    } snapshot_t;

    // Page sequence PRICE -> STATS -> TRADE -> PRICE; page 3 is unreachable.
    function automatic page_t page_advance(input page_t p);
        case (p)
            PG_PRICE: return PG_STATS;
            PG_STATS: return PG_TRADE;
            default:  return PG_PRICE;
        endcase
    endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running modulo-DIV counter with a 1-cycle wrap tick
// Purpose: counts 0..DIV-1 while en is high; tick is high in the cycle the count wraps.
// Ports: clk, reset (sync active-high), en (count enable), clr (sync clear, wins over en),
//        tick (combinational, 1 cycle per wrap).
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              W    = $clog2(DIV + 1);
    localparam logic [W-1:0]    LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_page_ctrl.sv
// rtl/display_page_ctrl.sv - page sequencer, halt snapshot/blink and match LED stretcher
// Purpose: drives the three 8-bit display_hex inputs from one of three value pages, rotating
//          automatically or on a key pulse; freezes a blinking snapshot while halted; stretches
//          the 1-cycle match pulse into a visible LED.
// Ports: clk, reset (sync active-high); buy_price, sell_price, spread_now, trade_count,
//        last_price (8b), state (2b) data inputs; halt_signal, match_signal, next_page, auto_en
//        controls; disp_a/b/c (8b), blank (6b), page (2b), match_led, frozen registered outputs.
module display_page_ctrl
    import display_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter int ROTATE_TICKS = 3,
    parameter int BLINK_DIV    = 12_500_000,
    parameter int STRETCH_CYC  = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] buy_price,
    input  logic [7:0] sell_price,
    input  logic [7:0] spread_now,
    input  logic [7:0] trade_count,
    input  logic [7:0] last_price,
    input  logic [1:0] state,
    input  logic       halt_signal,
    input  logic       match_signal,
    input  logic       next_page,
    input  logic       auto_en,
    output logic [7:0] disp_a,
    output logic [7:0] disp_b,
    output logic [7:0] disp_c,
    output logic [5:0] blank,
    output logic [1:0] page,
    output logic       match_led,
    output logic       frozen
);

    localparam int           RW           = $clog2(ROTATE_TICKS + 1);
    localparam int           SW           = $clog2(STRETCH_CYC + 1);
    localparam logic [RW-1:0] ROT_LAST     = RW'(ROTATE_TICKS - 1);
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYC);

    fsm_t          fsm_q, fsm_d;
    page_t         page_q, page_d;
    logic [RW-1:0] rot_cnt_q, rot_cnt_d;
    logic [SW-1:0] stretch_q, stretch_d;
    snapshot_t     snap_q, snap_d, live, src;
    logic          halt_q;
    logic          rot_tick, blink_tick;
    logic          is_frozen;
    logic          auto_step, auto_adv;
    logic [7:0]    a_d, b_d, c_d;

    assign is_frozen = (fsm_q != LIVE);
    assign page      = page_q;

    tick_divider #(.DIV(TICK_DIV)) u_rotate (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (1'b0),
        .tick  (rot_tick)
    );

    // Blink phase restarts from zero on every entry into the frozen states.
    tick_divider #(.DIV(BLINK_DIV)) u_blink (
        .clk   (clk),
        .reset (reset),
        .en    (is_frozen),
        .clr   (!is_frozen),
        .tick  (blink_tick)
    );

    always_comb begin
        live.buy_price   = buy_price;
        live.sell_price  = sell_price;
        live.spread_now  = spread_now;
        live.trade_count = trade_count;
        live.last_price  = last_price;
        live.state       = state;
    end

    // FSM next state; halt low always wins over a blink toggle.
    always_comb begin
        fsm_d  = fsm_q;
        snap_d = snap_q;
        case (fsm_q)
            LIVE: begin
                if (halt_signal && !halt_q) begin
                    fsm_d  = FROZEN_ON;
                    snap_d = live;
                end
            end
            FROZEN_ON: begin
                if (!halt_signal)    fsm_d = LIVE;
                else if (blink_tick) fsm_d = FROZEN_OFF;
            end
            FROZEN_OFF: begin
                if (!halt_signal)    fsm_d = LIVE;
                else if (blink_tick) fsm_d = FROZEN_ON;
            end
            default: fsm_d = LIVE;
        endcase
    end

    // Page selection; a key pulse coinciding with an auto advance moves just one page.
    always_comb begin
        auto_step = auto_en && !is_frozen && rot_tick;
        auto_adv  = auto_step && (rot_cnt_q == ROT_LAST);
        page_d    = page_q;
        rot_cnt_d = rot_cnt_q;
        if (next_page || auto_adv) begin
            page_d    = page_advance(page_q);
            rot_cnt_d = '0;
        end else if (auto_step) begin
            rot_cnt_d = rot_cnt_q + 1'b1;
        end
    end

    always_comb begin
        stretch_d = stretch_q;
        if (match_signal)         stretch_d = STRETCH_LOAD;
        else if (stretch_q != '0) stretch_d = stretch_q - 1'b1;
    end

    // Display values follow the next-state page/FSM so disp_* and page/blank change together.
    always_comb begin
        src = (fsm_d == LIVE) ? live : snap_d;
        a_d = src.buy_price;
        b_d = src.sell_price;
        c_d = src.spread_now;
        case (page_d)
            PG_STATS: begin
                a_d = src.trade_count;
                b_d = src.last_price;
                c_d = src.spread_now;
            end
            PG_TRADE: begin
                a_d = src.trade_count;
                b_d = src.last_price;
                c_d = {6'b0, src.state};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q     <= LIVE;
            page_q    <= PG_PRICE;
            rot_cnt_q <= '0;
            stretch_q <= '0;
            snap_q    <= '0;
            halt_q    <= 1'b0;
            disp_a    <= '0;
            disp_b    <= '0;
            disp_c    <= '0;
            blank     <= '0;
            match_led <= 1'b0;
            frozen    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            page_q    <= page_d;
            rot_cnt_q <= rot_cnt_d;
            stretch_q <= stretch_d;
            snap_q    <= snap_d;
            halt_q    <= halt_signal;
            disp_a    <= a_d;
            disp_b    <= b_d;
            disp_c    <= c_d;
            blank     <= (fsm_d == FROZEN_OFF) ? 6'h3F : 6'h00;
            match_led <= (stretch_d != '0);
            frozen    <= (fsm_d != LIVE);
        end
    end

endmodule

// File: tb/tb_display_page_ctrl.sv
// tb/tb_display_page_ctrl.sv - self-checking bench for display_page_ctrl
module tb_display_page_ctrl;

    localparam int TICK_DIV     = 4;
    localparam int ROTATE_TICKS = 2;
    localparam int BLINK_DIV    = 3;
    localparam int STRETCH_CYC  = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] buy_price, sell_price, spread_now, trade_count, last_price;
    logic [1:0] st;
    logic       halt_signal, match_signal, next_page, auto_en;
    logic [7:0] disp_a, disp_b, disp_c;
    logic [5:0] blank;
    logic [1:0] page;
    logic       match_led, frozen;

    always #5 clk = ~clk;

    display_page_ctrl #(
        .TICK_DIV     (TICK_DIV),
        .ROTATE_TICKS (ROTATE_TICKS),
        .BLINK_DIV    (BLINK_DIV),
        .STRETCH_CYC  (STRETCH_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .buy_price    (buy_price),
        .sell_price   (sell_price),
        .spread_now   (spread_now),
        .trade_count  (trade_count),
        .last_price   (last_price),
        .state        (st),
        .halt_signal  (halt_signal),
        .match_signal (match_signal),
        .next_page    (next_page),
        .auto_en      (auto_en),
        .disp_a       (disp_a),
        .disp_b       (disp_b),
        .disp_c       (disp_c),
        .blank        (blank),
        .page         (page),
        .match_led    (match_led),
        .frozen       (frozen)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: time measured in cycles since reset release.
    int         cyc;
    int         m_page;
    int         m_ticks;
    bit         m_frozen;
    int         freeze_at;
    int         last_match;
    bit         halt_prev;
    logic [7:0] s_buy, s_sell, s_spread, s_count, s_last;
    logic [1:0] s_st;
    logic [23:0] e_disp;
    logic [5:0]  e_blank;
    bit          e_led;

    function automatic logic [23:0] page_view(input int pg, input logic [7:0] b, input logic [7:0] s,
                                             input logic [7:0] sp, input logic [7:0] c,
                                             input logic [7:0] l, input logic [1:0] fs);
        if (pg == 0)      return {b, s, sp};
        else if (pg == 1) return {c, l, sp};
        else              return {c, l, 6'b0, fs};
    endfunction

    task automatic model_edge();
        bit tick, adv;
        if (reset) begin
            cyc = 0; m_page = 0; m_ticks = 0; m_frozen = 0; freeze_at = 0;
            last_match = -1000; halt_prev = 0;
            {s_buy, s_sell, s_spread, s_count, s_last, s_st} = '0;
            e_disp = '0; e_blank = '0; e_led = 0;
            return;
        end
        tick = (cyc % TICK_DIV) == TICK_DIV - 1;
        adv  = auto_en && !m_frozen && tick && (m_ticks + 1 == ROTATE_TICKS);
        if (next_page || adv) begin
            m_page  = (m_page + 1) % 3;
            m_ticks = 0;
        end else if (auto_en && !m_frozen && tick) begin
            m_ticks++;
        end
        if (!m_frozen) begin
            if (halt_signal && !halt_prev) begin
                m_frozen = 1; freeze_at = cyc;
                s_buy = buy_price; s_sell = sell_price; s_spread = spread_now;
                s_count = trade_count; s_last = last_price; s_st = st;
            end
        end else if (!halt_signal) begin
            m_frozen = 0;
        end
        halt_prev = halt_signal;
        e_blank = (m_frozen && (((cyc - freeze_at) / BLINK_DIV) % 2 == 1)) ? 6'h3F : 6'h00;
        if (match_signal) last_match = cyc;
        e_led = (cyc - last_match) < STRETCH_CYC;
        if (m_frozen) e_disp = page_view(m_page, s_buy, s_sell, s_spread, s_count, s_last, s_st);
        else          e_disp = page_view(m_page, buy_price, sell_price, spread_now, trade_count, last_price, st);
        cyc++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("disp",   {8'h0, disp_a, disp_b, disp_c}, {8'h0, e_disp});
        check("blank",  32'(blank),     32'(e_blank));
        check("page",   32'(page),      32'(m_page));
        check("led",    32'(match_led), 32'(e_led));
        check("frozen", 32'(frozen),    32'(m_frozen));
    endtask

    initial begin
        bit found;
        reset = 1; buy_price = 0; sell_price = 0; spread_now = 0; trade_count = 0;
        last_price = 0; st = 0; halt_signal = 0; match_signal = 0; next_page = 0; auto_en = 0;
        cycle(); cycle();
        reset = 0;

        buy_price = 8'h12; sell_price = 8'h34; spread_now = 8'h22;
        trade_count = 8'h07; last_price = 8'h41;
        repeat (4) cycle();

        auto_en = 1; st = 2'b10;
        repeat (30) cycle();

        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (m_page == 1 && !m_frozen && (cyc % TICK_DIV) == TICK_DIV - 1 &&
                m_ticks == ROTATE_TICKS - 1) begin
                next_page = 1; found = 1;
            end
            cycle();
            next_page = 0;
        end
        check("coincide_found", 32'(found), 32'd1);
        repeat (10) cycle();

        buy_price = 8'h55; halt_signal = 1;
        cycle();
        buy_price = 8'h66;
        repeat (6) cycle();
        next_page = 1; cycle(); next_page = 0;
        repeat (6) cycle();
        halt_signal = 0;
        repeat (3) cycle();

        match_signal = 1; cycle(); match_signal = 0;
        cycle(); cycle();
        match_signal = 1; cycle(); match_signal = 0;
        repeat (8) cycle();

        auto_en = 0;
        for (int i = 0; i < 3 && m_page != 2; i++) begin
            next_page = 1; cycle(); next_page = 0;
        end
        halt_signal = 1; match_signal = 1; cycle(); match_signal = 0;
        for (int i = 0; i < 8 && e_blank != 6'h3F; i++) cycle();
        check("reached_off", 32'(e_blank), 32'h3F);
        reset = 1; cycle(); reset = 0;
        repeat (4) cycle();
        halt_signal = 0; auto_en = 1;
        repeat (2) cycle();

        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 499) == 0);
            match_signal = ($urandom_range(0, 14) == 0);
            next_page    = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 39) == 0)  halt_signal = ~halt_signal;
            if ($urandom_range(0, 99) == 0)  auto_en = ~auto_en;
            if ($urandom_range(0, 3) == 0) begin
                buy_price   = 8'($urandom); sell_price = 8'($urandom);
                spread_now  = 8'($urandom); trade_count = 8'($urandom);
                last_price  = 8'($urandom); st = 2'($urandom);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
